// File: rtl/memory_fault_log.sv
// memory_fault_log: timestamped FIFO of blocked accesses from the address-window
// fault checker. The host drains records over a valid/ready port. A level interrupt
// is raised while records are pending, and faults lost to a full FIFO are counted.
// Optional feature: define MEMORY_FAULT_LOG_DEDUP_EN to suppress repeat faults
// whose address matches the last pushed address.
module memory_fault_log #(
    parameter int DEPTH = 8,
    parameter int AW    = 64,
    parameter int TS_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fault_in,
    input  logic [AW-1:0]              fault_addr,
    input  logic                       clear,
    input  logic                       irq_en,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [AW-1:0]              rd_addr,
    output logic [TS_W-1:0]            rd_ts,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_W-1:0]           drop_count,
    output logic [CNT_W-1:0]           dup_count,
    output logic                       irq
);

    localparam int PW = $clog2(DEPTH);

    // The counters carry one extra bit over the pointers, so full and empty can be
    // told apart from the difference alone.
    logic [PW:0]     wr_cnt, rd_cnt;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [AW-1:0]   mem_addr [DEPTH];
    logic [TS_W-1:0] mem_ts   [DEPTH];
    logic [TS_W-1:0] ts;
    logic            full, pop, cand, push, drop_ev, dup_hit;

    assign wr_ptr   = wr_cnt[PW-1:0];
    assign rd_ptr   = rd_cnt[PW-1:0];
    assign level    = wr_cnt - rd_cnt;
    assign full     = level[PW];
    assign rd_valid = (level != '0);
    assign irq      = irq_en && rd_valid;
    assign rd_addr  = mem_addr[rd_ptr];
    assign rd_ts    = mem_ts[rd_ptr];

`ifdef MEMORY_FAULT_LOG_DEDUP_EN
    logic [AW-1:0] ref_addr;
    logic          ref_vld;

    assign dup_hit = fault_in && !clear && ref_vld && (ref_addr == fault_addr);

    // Dedup reference follows the last successful push; it is invalidated by a flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ref_addr <= '0;
            ref_vld  <= 1'b0;
        end else if (clear) begin
            ref_vld  <= 1'b0;
        end else if (push) begin
            ref_addr <= fault_addr;
            ref_vld  <= 1'b1;
        end
    end

    // Duplicates are counted even when the FIFO is full. The count saturates at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            dup_count <= '0;
        else if (clear)
            dup_count <= '0;
        else if (dup_hit && (dup_count != '1))
            dup_count <= dup_count + 1'b1;
    end
`else
    assign dup_hit   = 1'b0;
    assign dup_count = '0;
`endif

    // clear overrides both sides. A fault during clear is neither logged nor counted.
    assign pop     = rd_valid && rd_ready && !clear;
    assign cand    = fault_in && !clear && !dup_hit;
    assign push    = cand && (!full || pop);
    assign drop_ev = cand && full && !pop;

    // Free-running timestamp. It wraps naturally and is not affected by clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ts <= '0;
        else
            ts <= ts + 1'b1;
    end

    // Write and read counters. A flush snaps the read counter to the write counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else if (clear) begin
            rd_cnt <= wr_cnt;
        end else begin
            if (push) wr_cnt <= wr_cnt + 1'b1;
            if (pop)  rd_cnt <= rd_cnt + 1'b1;
        end
    end

    // Record storage. It is zeroed on reset so the head outputs read zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_addr[i] <= '0;
                mem_ts[i]   <= '0;
            end
        end else if (push) begin
            mem_addr[wr_ptr] <= fault_addr;
            mem_ts[wr_ptr]   <= ts;
        end
    end

    // Count overflow losses. The count saturates at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            drop_count <= '0;
        else if (clear)
            drop_count <= '0;
        else if (drop_ev && (drop_count != '1))
            drop_count <= drop_count + 1'b1;
    end

endmodule

// File: tb/tb_memory_fault_log.sv
// Directed bench for memory_fault_log. A second instance with TS_W=4 covers timestamp wrap.
module tb_memory_fault_log;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fault_in = 1'b0, clear = 1'b0, irq_en = 1'b0, rd_ready = 1'b0;
    logic [63:0] fault_addr = '0;
    logic        rd_valid, irq;
    logic [63:0] rd_addr;
    logic [31:0] rd_ts;
    logic [3:0]  level;
    logic [15:0] drop_count, dup_count;

    logic        rst4 = 1'b1, fault4 = 1'b0, rd_ready4 = 1'b0;
    logic [63:0] addr4 = '0;
    logic        rd_valid4, irq4;
    logic [63:0] rd_addr4;
    logic [3:0]  rd_ts4;
    logic [3:0]  level4;
    logic [15:0] drop4, dup4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    memory_fault_log dut (
        .clk(clk), .reset(reset), .fault_in(fault_in), .fault_addr(fault_addr),
        .clear(clear), .irq_en(irq_en), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_addr(rd_addr), .rd_ts(rd_ts), .level(level), .drop_count(drop_count),
        .dup_count(dup_count), .irq(irq)
    );

    memory_fault_log #(.TS_W(4)) dut4 (
        .clk(clk), .reset(rst4), .fault_in(fault4), .fault_addr(addr4),
        .clear(1'b0), .irq_en(1'b0), .rd_valid(rd_valid4), .rd_ready(rd_ready4),
        .rd_addr(rd_addr4), .rd_ts(rd_ts4), .level(level4), .drop_count(drop4),
        .dup_count(dup4), .irq(irq4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick();
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %0b exp 0", rd_valid); end
        n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL rst_level got %0d exp 0", level); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL rst_irq got %0b exp 0", irq); end
        n_cmp++; if (rd_addr !== 64'd0 || rd_ts !== 32'd0) begin n_err++; $display("FAIL rst_head got %h/%0d exp 0/0", rd_addr, rd_ts); end
        n_cmp++; if (drop_count !== 16'd0 || dup_count !== 16'd0) begin n_err++; $display("FAIL rst_counts got %0d/%0d exp 0/0", drop_count, dup_count); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        repeat (5) tick();
        fault_in = 1'b1; fault_addr = 64'h1000;
        tick();
        fault_in = 1'b0;
        n_cmp++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got %0b exp 1", rd_valid); end
        n_cmp++; if (rd_addr !== 64'h1000 || rd_ts !== 32'd5) begin n_err++; $display("FAIL basic_rec0 got %h/%0d exp 1000/5", rd_addr, rd_ts); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL basic_irq_off got %0b exp 0", irq); end
        tick();
        fault_in = 1'b1; fault_addr = 64'h2000;
        tick();
        fault_in = 1'b0;
        n_cmp++; if (level !== 4'd2) begin n_err++; $display("FAIL basic_level got %0d exp 2", level); end
        n_cmp++; if (rd_addr !== 64'h1000) begin n_err++; $display("FAIL basic_head_hold got %h exp 1000", rd_addr); end
        irq_en = 1'b1; #1;
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL basic_irq_on got %0b exp 1", irq); end
        rd_ready = 1'b1;
        tick();
        n_cmp++; if (rd_addr !== 64'h2000 || rd_ts !== 32'd7 || level !== 4'd1) begin n_err++; $display("FAIL basic_rec1 got %h/%0d/%0d exp 2000/7/1", rd_addr, rd_ts, level); end
        tick();
        n_cmp++; if (rd_valid !== 1'b0 || irq !== 1'b0) begin n_err++; $display("FAIL basic_empty got %0b/%0b exp 0/0", rd_valid, irq); end
        tick();
        rd_ready = 1'b0;
        n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL empty_pop got level %0d exp 0", level); end
    endtask

    task automatic test_overflow();
        logic [63:0] exp;
        do_clear();
        for (int i = 0; i < 10; i++) begin
            fault_in = 1'b1; fault_addr = 64'h100 + 64'(i);
            tick();
        end
        fault_in = 1'b0;
        n_cmp++; if (level !== 4'd8) begin n_err++; $display("FAIL ovf_level got %0d exp 8", level); end
        n_cmp++; if (drop_count !== 16'd2) begin n_err++; $display("FAIL ovf_drop got %0d exp 2", drop_count); end
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp = 64'h100 + 64'(i);
            n_cmp++; if (rd_addr !== exp || irq !== 1'b1) begin n_err++; $display("FAIL ovf_drain%0d got %h irq %0b exp %h irq 1", i, rd_addr, irq, exp); end
            tick();
        end
        rd_ready = 1'b0;
        n_cmp++; if (irq !== 1'b0 || rd_valid !== 1'b0) begin n_err++; $display("FAIL ovf_irq_fall got %0b/%0b exp 0/0", irq, rd_valid); end
    endtask

    task automatic test_full_pop();
        logic [63:0] exp;
        do_clear();
        n_cmp++; if (drop_count !== 16'd0) begin n_err++; $display("FAIL clear_drop got %0d exp 0", drop_count); end
        for (int i = 0; i < 8; i++) begin
            fault_in = 1'b1; fault_addr = 64'h300 + 64'(i);
            tick();
        end
        fault_addr = 64'h3FF; rd_ready = 1'b1;
        tick();
        fault_in = 1'b0; rd_ready = 1'b0;
        n_cmp++; if (level !== 4'd8 || drop_count !== 16'd0) begin n_err++; $display("FAIL fullpop_level got %0d drop %0d exp 8 drop 0", level, drop_count); end
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp = (i < 7) ? 64'h301 + 64'(i) : 64'h3FF;
            n_cmp++; if (rd_addr !== exp) begin n_err++; $display("FAIL fullpop_drain%0d got %h exp %h", i, rd_addr, exp); end
            tick();
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_clear();
        do_clear();
        for (int i = 0; i < 3; i++) begin
            fault_in = 1'b1; fault_addr = 64'h400 + 64'(i);
            tick();
        end
        fault_in = 1'b0;
        n_cmp++; if (level !== 4'd3) begin n_err++; $display("FAIL clr_pre_level got %0d exp 3", level); end
        clear = 1'b1; fault_in = 1'b1; fault_addr = 64'h4AA; rd_ready = 1'b1;
        tick();
        clear = 1'b0; fault_in = 1'b0; rd_ready = 1'b0;
        n_cmp++; if (level !== 4'd0 || rd_valid !== 1'b0 || drop_count !== 16'd0) begin n_err++; $display("FAIL clr_post got %0d/%0b/%0d exp 0/0/0", level, rd_valid, drop_count); end
        repeat (3) tick();
        n_cmp++; if (rd_valid !== 1'b0 || dup_count !== 16'd0) begin n_err++; $display("FAIL clr_never_out got %0b/%0d exp 0/0", rd_valid, dup_count); end
    endtask

    task automatic test_dedup();
        logic [63:0] seq [4];
        logic [63:0] exp [4];
        int n_exp;
        seq[0] = 64'hA0; seq[1] = 64'hA0; seq[2] = 64'hB0; seq[3] = 64'hA0;
`ifdef MEMORY_FAULT_LOG_DEDUP_EN
        exp[0] = 64'hA0; exp[1] = 64'hB0; exp[2] = 64'hA0; exp[3] = 64'h0;
        n_exp = 3;
`else
        exp = seq;
        n_exp = 4;
`endif
        do_clear();
        for (int i = 0; i < 4; i++) begin
            fault_in = 1'b1; fault_addr = seq[i];
            tick();
        end
        fault_in = 1'b0;
        n_cmp++; if (level !== 4'(n_exp)) begin n_err++; $display("FAIL dedup_level got %0d exp %0d", level, n_exp); end
        n_cmp++; if (dup_count !== 16'(4 - n_exp)) begin n_err++; $display("FAIL dedup_count got %0d exp %0d", dup_count, 4 - n_exp); end
        rd_ready = 1'b1;
        for (int i = 0; i < n_exp; i++) begin
            n_cmp++; if (rd_addr !== exp[i]) begin n_err++; $display("FAIL dedup_rec%0d got %h exp %h", i, rd_addr, exp[i]); end
            tick();
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        do_clear();
        for (int i = 0; i < 3; i++) begin
            fault_in = 1'b1; fault_addr = 64'h500 + 64'(i);
            tick();
        end
        fault_in = 1'b0; rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        reset = 1'b1;
        #1;
        n_cmp++; if (rd_valid !== 1'b0 || level !== 4'd0 || irq !== 1'b0) begin n_err++; $display("FAIL midrst_state got %0b/%0d/%0b exp 0/0/0", rd_valid, level, irq); end
        n_cmp++; if (rd_addr !== 64'd0 || rd_ts !== 32'd0) begin n_err++; $display("FAIL midrst_head got %h/%0d exp 0/0", rd_addr, rd_ts); end
        tick();
        reset = 1'b0;
        tick();
        fault_in = 1'b1; fault_addr = 64'h600;
        tick();
        fault_in = 1'b0;
        n_cmp++; if (rd_addr !== 64'h600 || rd_ts !== 32'd1) begin n_err++; $display("FAIL midrst_ts got %h/%0d exp 600/1", rd_addr, rd_ts); end
    endtask

    task automatic test_ts_wrap();
        rst4 = 1'b0;
        repeat (14) tick();
        fault4 = 1'b1; addr4 = 64'hE;
        tick();
        fault4 = 1'b0;
        n_cmp++; if (rd_ts4 !== 4'd14) begin n_err++; $display("FAIL wrap_ts0 got %0d exp 14", rd_ts4); end
        tick(); tick();
        fault4 = 1'b1; addr4 = 64'h1;
        tick();
        fault4 = 1'b0; rd_ready4 = 1'b1;
        tick();
        rd_ready4 = 1'b0;
        n_cmp++; if (rd_ts4 !== 4'd1 || rd_addr4 !== 64'h1 || level4 !== 4'd1) begin n_err++; $display("FAIL wrap_ts1 got %0d/%h/%0d exp 1/1/1", rd_ts4, rd_addr4, level4); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_pop();
        test_clear();
        test_dedup();
        test_reset_mid_drain();
        test_ts_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
